// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path.
// Note width, allocator state codes, MIDI note range.
package synth_pkg;

  localparam int NOTE_W = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [NOTE_W-1:0] MIDI_NOTE_MIN = 7'd0;
  localparam logic [NOTE_W-1:0] MIDI_NOTE_MAX = 7'd127;

  typedef logic [NOTE_W-1:0] note_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Saturating per-voice age counters.
// Read port follows the allocator's scan index.
module voice_age_tracker
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int VOICE_IDX_W = 2,
  parameter int AGE_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit,
  input  logic [VOICE_IDX_W-1:0] chosen_idx,
  input  logic [NUM_VOICES-1:0]  gate,
  input  logic [VOICE_IDX_W-1:0] scan_idx,
  output logic [AGE_W-1:0]       scan_age
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic [AGE_W-1:0] age_q [NUM_VOICES];

  // Chosen voice restarts at 0; other sounding voices grow and stick at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++)
        age_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (chosen_idx == VOICE_IDX_W'(i))
          age_q[i] <= '0;
        else if (gate[i] && age_q[i] != AGE_MAX)
          age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  assign scan_age = age_q[scan_idx];

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger, free, or steal oldest.
// One voice examined per scan cycle, single commit cycle.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int VOICE_IDX_W = 2,
  parameter int AGE_W       = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     eventValid,
  output logic                     eventReady,
  input  logic                     eventIsNoteOn,
  input  logic [NOTE_W-1:0]        eventNote,
  input  logic                     allNotesOff,
  output logic [NUM_VOICES-1:0]    voiceGate,
  output logic [NOTE_W*NUM_VOICES-1:0] voiceNote,
  output logic [NUM_VOICES-1:0]    voiceTrigger,
  output logic [7:0]               stealCount
);

  localparam logic [VOICE_IDX_W-1:0] LAST_IDX =
    VOICE_IDX_W'(NUM_VOICES - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       idle;
  logic       scan_en;
  logic       commit_en;
  logic       accept;
  logic       last_scan;

  logic                   ev_on_q;
  note_t                  ev_note_q;
  logic [VOICE_IDX_W-1:0] scan_idx_q;

  logic                   match_hit_q;
  logic [VOICE_IDX_W-1:0] match_idx_q;
  logic                   free_hit_q;
  logic [VOICE_IDX_W-1:0] free_idx_q;
  logic                   old_hit_q;
  logic [VOICE_IDX_W-1:0] old_idx_q;
  logic [AGE_W-1:0]       old_age_q;
  logic [AGE_W-1:0]       scan_age;

  logic [NUM_VOICES-1:0]  gate_q;
  note_t                  note_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]  trig_q;
  logic [7:0]             steal_q;

  logic                   cur_gate;
  note_t                  cur_note;

  logic                   sel_retrig;
  logic                   sel_assign;
  logic                   sel_steal;
  logic                   sel_release;
  logic                   age_commit;
  logic [VOICE_IDX_W-1:0] tgt_idx;

  assign accept    = eventValid && idle && !allNotesOff;
  assign last_scan = scan_idx_q == LAST_IDX;

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state: IDLE -> SCAN (one voice per cycle) -> COMMIT -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SCAN;
      ST_SCAN:   if (last_scan) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State decode strobes.
  always_comb begin
    idle      = 1'b0;
    scan_en   = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      ST_IDLE:   idle      = 1'b1;
      ST_SCAN:   scan_en   = 1'b1;
      ST_COMMIT: commit_en = 1'b1;
      default:   idle      = 1'b0;
    endcase
  end

  assign eventReady = idle;

  assign cur_gate = gate_q[scan_idx_q];
  assign cur_note = note_q[scan_idx_q];

  // Latch the event on accept, then walk the voices recording candidates.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      scan_idx_q  <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
      old_hit_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else if (accept) begin
      ev_on_q     <= eventIsNoteOn;
      ev_note_q   <= eventNote;
      scan_idx_q  <= '0;
      match_hit_q <= 1'b0;
      free_hit_q  <= 1'b0;
      old_hit_q   <= 1'b0;
      old_age_q   <= '0;
    end else if (scan_en) begin
      scan_idx_q <= scan_idx_q + VOICE_IDX_W'(1);
      if (!match_hit_q && cur_gate && cur_note == ev_note_q) begin
        match_hit_q <= 1'b1;
        match_idx_q <= scan_idx_q;
      end
      if (!free_hit_q && !cur_gate) begin
        free_hit_q <= 1'b1;
        free_idx_q <= scan_idx_q;
      end
      // Strict compare keeps the lowest index on equal ages.
      if (cur_gate && (!old_hit_q || scan_age > old_age_q)) begin
        old_hit_q <= 1'b1;
        old_idx_q <= scan_idx_q;
        old_age_q <= scan_age;
      end
    end
  end

  assign sel_retrig  = commit_en && ev_on_q && match_hit_q;
  assign sel_assign  = commit_en && ev_on_q && !match_hit_q
                       && free_hit_q;
  assign sel_steal   = commit_en && ev_on_q && !match_hit_q
                       && !free_hit_q;
  assign sel_release = commit_en && !ev_on_q && match_hit_q;
  assign age_commit  = sel_retrig || sel_assign || sel_steal;

  // Pick the voice the commit acts on.
  always_comb begin
    tgt_idx = old_idx_q;
    unique case (1'b1)
      sel_retrig:  tgt_idx = match_idx_q;
      sel_release: tgt_idx = match_idx_q;
      sel_assign:  tgt_idx = free_idx_q;
      default:     tgt_idx = old_idx_q;
    endcase
  end

  // Voice bank registers; trigger is a one-cycle pulse after commit.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      gate_q  <= '0;
      trig_q  <= '0;
      steal_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++)
        note_q[i] <= '0;
    end else begin
      trig_q <= '0;
      if (idle && allNotesOff)
        gate_q <= '0;
      unique case (1'b1)
        sel_retrig: trig_q[tgt_idx] <= 1'b1;
        sel_assign, sel_steal: begin
          gate_q[tgt_idx] <= 1'b1;
          note_q[tgt_idx] <= ev_note_q;
          trig_q[tgt_idx] <= 1'b1;
        end
        sel_release: gate_q[tgt_idx] <= 1'b0;
        default: ;
      endcase
      if (sel_steal)
        steal_q <= steal_q + 8'd1;
    end
  end

  voice_age_tracker #(
    .NUM_VOICES  (NUM_VOICES),
    .VOICE_IDX_W (VOICE_IDX_W),
    .AGE_W       (AGE_W)
  ) u_age (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .commit     (age_commit),
    .chosen_idx (tgt_idx),
    .gate       (gate_q),
    .scan_idx   (scan_idx_q),
    .scan_age   (scan_age)
  );

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_note
    assign voiceNote[NOTE_W*i +: NOTE_W] = note_q[i];
  end

  assign voiceGate    = gate_q;
  assign voiceTrigger = trig_q;
  assign stealCount   = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomised and directed bench for voice_allocator.
// Reference model tracks voices as plain integer arrays.
module tb_voice_allocator;

  localparam int NV = 4;

  logic        CLOCK_50;
  logic        RESET;
  logic        eventValid;
  logic        eventReady;
  logic        eventIsNoteOn;
  logic [6:0]  eventNote;
  logic        allNotesOff;
  logic [3:0]  voiceGate;
  logic [27:0] voiceNote;
  logic [3:0]  voiceTrigger;
  logic [7:0]  stealCount;

  int n_checks;
  int n_errors;

  int m_gate [NV];
  int m_note [NV];
  int m_age  [NV];
  int m_steal;

  voice_allocator #(
    .NUM_VOICES  (4),
    .VOICE_IDX_W (2),
    .AGE_W       (8)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET         (RESET),
    .eventValid    (eventValid),
    .eventReady    (eventReady),
    .eventIsNoteOn (eventIsNoteOn),
    .eventNote     (eventNote),
    .allNotesOff   (allNotesOff),
    .voiceGate     (voiceGate),
    .voiceNote     (voiceNote),
    .voiceTrigger  (voiceTrigger),
    .stealCount    (stealCount)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_gate();
    logic [3:0] r;
    for (int i = 0; i < NV; i++) r[i] = (m_gate[i] != 0);
    return r;
  endfunction

  function automatic logic [27:0] exp_notes();
    logic [27:0] r;
    int v;
    for (int i = 0; i < NV; i++) begin
      v = m_note[i];
      r[7*i +: 7] = v[6:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0;
      m_note[i] = 0;
      m_age[i]  = 0;
    end
    m_steal = 0;
  endtask

  // Applies one event to the model; returns the expected trigger mask.
  task automatic model_event(input bit on, input int n,
                             output logic [3:0] trig);
    int match, free, old, ch;
    match = -1; free = -1; old = -1;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_gate[i] != 0 && m_note[i] == n) match = i;
      if (free < 0 && m_gate[i] == 0) free = i;
      if (m_gate[i] != 0 && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    trig = 4'b0;
    if (!on) begin
      if (match >= 0) m_gate[match] = 0;
      return;
    end
    if (match >= 0) ch = match;
    else if (free >= 0) ch = free;
    else begin
      ch = old;
      m_steal = (m_steal + 1) % 256;
    end
    for (int i = 0; i < NV; i++)
      if (i != ch && m_gate[i] != 0 && m_age[i] < 255) m_age[i]++;
    m_age[ch]  = 0;
    m_gate[ch] = 1;
    m_note[ch] = n;
    trig[ch]   = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_gate"}, 32'(voiceGate), 32'(exp_gate()));
    check({tag, "_note"}, 32'(voiceNote), 32'(exp_notes()));
    check({tag, "_steal"}, 32'(stealCount), 32'(m_steal));
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET = 1'b1;
    eventValid = 1'b0;
    allNotesOff = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    model_clear();
    check_state("rst");
    check("rst_trig", 32'(voiceTrigger), 32'd0);
    check("rst_ready", 32'(eventReady), 32'd1);
  endtask

  // Offers an event (optionally together with allNotesOff first) and
  // checks ready/trigger every cycle until the result is visible.
  task automatic send_event(input bit on, input int n, input bit aoff);
    logic [3:0] trig;
    @(negedge CLOCK_50);
    check("ready_idle", 32'(eventReady), 32'd1);
    eventValid    = 1'b1;
    eventIsNoteOn = on;
    eventNote     = 7'(n);
    allNotesOff   = aoff;
    if (aoff) begin
      @(negedge CLOCK_50);
      allNotesOff = 1'b0;
      for (int i = 0; i < NV; i++) m_gate[i] = 0;
      check("aoff_gate", 32'(voiceGate), 32'(exp_gate()));
      check("aoff_ready", 32'(eventReady), 32'd1);
    end
    model_event(on, n, trig);
    @(negedge CLOCK_50);
    eventValid = 1'b0;
    for (int k = 1; k <= NV + 2; k++) begin
      if (k > 1) @(negedge CLOCK_50);
      check("ready", 32'(eventReady), 32'(k == NV + 2));
      check("trig", 32'(voiceTrigger),
            (k == NV + 2) ? 32'(trig) : 32'd0);
    end
    check_state("ev");
  endtask

  initial begin
    RESET = 1'b1;
    eventValid = 1'b0;
    eventIsNoteOn = 1'b0;
    eventNote = 7'd0;
    allNotesOff = 1'b0;
    n_checks = 0;
    n_errors = 0;
    model_clear();
    do_reset();

    send_event(1, 60, 0);
    send_event(1, 64, 0);
    check("t1_gate", 32'(voiceGate), 32'h3);

    do_reset();
    send_event(1, 60, 0);
    send_event(1, 60, 0);
    check("t2_gate", 32'(voiceGate), 32'h1);

    do_reset();
    send_event(1, 60, 0);
    send_event(1, 62, 0);
    send_event(1, 64, 0);
    send_event(1, 65, 0);
    send_event(1, 67, 0);
    check("t3_v0", 32'(voiceNote[6:0]), 32'd67);
    check("t3_steal", 32'(stealCount), 32'd1);

    do_reset();
    send_event(1, 60, 0);
    send_event(1, 62, 0);
    send_event(1, 64, 0);
    send_event(1, 65, 0);
    send_event(0, 62, 0);
    check("t4_gate", 32'(voiceGate), 32'hd);
    send_event(0, 99, 0);
    check("t4_nochg", 32'(voiceGate), 32'hd);

    send_event(1, 70, 1);
    check("t5_gate", 32'(voiceGate), 32'h1);

    do_reset();
    for (int e = 0; e < 300; e++) begin
      int r;
      r = int'($urandom_range(0, 99));
      send_event(r < 60, int'($urandom_range(60, 65)), r >= 92);
    end

    do_reset();
    send_event(1, 60, 0);
    send_event(1, 61, 0);
    send_event(1, 62, 0);
    send_event(1, 63, 0);
    for (int e = 0; e < 254; e++) send_event(1, 60, 0);
    send_event(1, 70, 0);
    check("sat_v1", 32'(voiceNote[13:7]), 32'd70);

    send_event(1, 71, 0);
    @(negedge CLOCK_50);
    eventValid = 1'b1;
    eventIsNoteOn = 1'b1;
    eventNote = 7'd90;
    @(negedge CLOCK_50);
    eventValid = 1'b0;
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    RESET = 1'b0;
    model_clear();
    check_state("rscan");
    check("rscan_trig", 32'(voiceTrigger), 32'd0);
    @(negedge CLOCK_50);
    check("rscan_ready", 32'(eventReady), 32'd1);
    check_state("rscan2");
    send_event(1, 61, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
